// File: rtl/uk101_clk_pkg.sv
// Clock-enable constants for the 48 MHz clk_sys domain and the cpuOverclock divisor map.
package uk101_clk_pkg;

  localparam int unsigned DIV_W_DEF  = 6;
  localparam int unsigned FRAC_W_DEF = 8;

  localparam logic [DIV_W_DEF-1:0]  CE_PIX_LO_M1     = 6'd11;
  localparam logic [DIV_W_DEF-1:0]  CE_PIX_HI_M1     = 6'd5;
  localparam logic [DIV_W_DEF-1:0]  CE_CPU_1M_M1     = 6'd47;
  localparam logic [DIV_W_DEF-1:0]  CE_CPU_2M_M1     = 6'd23;
  localparam logic [DIV_W_DEF-1:0]  CE_CPU_4M_M1     = 6'd11;
  localparam logic [DIV_W_DEF-1:0]  CE_CPU_8M_M1     = 6'd5;
  localparam logic [DIV_W_DEF-1:0]  CE_CPU_10M_M1    = 6'd3;
  localparam logic [FRAC_W_DEF-1:0] CE_CPU_10M_FRAC  = 8'd205;

  typedef enum logic [2:0] {
    OC_1M  = 3'd0,
    OC_2M  = 3'd1,
    OC_4M  = 3'd2,
    OC_8M  = 3'd3,
    OC_10M = 3'd4
  } cpu_oc_e;

  // 10 MHz only hits its rate when paired with CE_CPU_10M_FRAC under CE_FRAC_EN.
  function automatic logic [DIV_W_DEF-1:0] cpu_oc_div_m1(input logic [2:0] oc);
    case (cpu_oc_e'(oc))
      OC_1M:   cpu_oc_div_m1 = CE_CPU_1M_M1;
      OC_2M:   cpu_oc_div_m1 = CE_CPU_2M_M1;
      OC_4M:   cpu_oc_div_m1 = CE_CPU_4M_M1;
      OC_8M:   cpu_oc_div_m1 = CE_CPU_8M_M1;
      OC_10M:  cpu_oc_div_m1 = CE_CPU_10M_M1;
      default: cpu_oc_div_m1 = CE_CPU_1M_M1;
    endcase
  endfunction

endpackage

// File: rtl/ce_divider_ch.sv
// One clock-enable channel: programmable period, mid-period enable, pause, sync.
// Fractional period stretching is built only when CE_FRAC_EN is defined.
module ce_divider_ch
  import uk101_clk_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
`ifdef CE_FRAC_EN
  , parameter int unsigned FRAC_W = FRAC_W_DEF
`endif
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_m1,
`ifdef CE_FRAC_EN
  input  logic [FRAC_W-1:0] frac,
`endif
  input  logic             pause,
  input  logic             sync,
  output logic             ce,
  output logic             ce_half,
  output logic             switching
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic             load_q, load_d;
  logic             ce_q, ce_d;
  logic             ce_half_q, ce_half_d;
  logic             do_wrap;
`ifdef CE_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W:0]   frac_sum;
`endif

  always_comb begin
    count_d   = count_q;
    active_d  = active_q;
    load_d    = load_q;
    ce_d      = 1'b0;
    ce_half_d = 1'b0;
    do_wrap   = 1'b0;
`ifdef CE_FRAC_EN
    acc_d     = acc_q;
    stretch_d = stretch_q;
    frac_sum  = {1'b0, acc_q} + {1'b0, frac};
`endif
    if (sync) begin
      count_d  = '0;
      active_d = div_m1;
      load_d   = 1'b0;
`ifdef CE_FRAC_EN
      acc_d     = '0;
      stretch_d = 1'b0;
`endif
    end else if (pause) begin
      // hold everything; a pending divisor change stays pending
    end else if (load_q) begin
      active_d = div_m1;
      count_d  = '0;
      load_d   = 1'b0;
    end else if (count_q != active_q) begin
      count_d   = count_q + DIV_W'(1);
      ce_half_d = (count_q == (active_q >> 1));
    end else begin
`ifdef CE_FRAC_EN
      // A carry owes one extra cycle: park at the limit and emit ce next cycle.
      if (!stretch_q) acc_d = frac_sum[FRAC_W-1:0];
      if (!stretch_q && frac_sum[FRAC_W]) begin
        stretch_d = 1'b1;
      end else begin
        stretch_d = 1'b0;
        do_wrap   = 1'b1;
      end
`else
      do_wrap = 1'b1;
`endif
    end

    if (do_wrap) begin
      count_d   = '0;
      ce_d      = 1'b1;
      ce_half_d = (active_q == '0);
      active_d  = div_m1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      active_q  <= '0;
      load_q    <= 1'b1;
      ce_q      <= 1'b0;
      ce_half_q <= 1'b0;
`ifdef CE_FRAC_EN
      acc_q     <= '0;
      stretch_q <= 1'b0;
`endif
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      load_q    <= load_d;
      ce_q      <= ce_d;
      ce_half_q <= ce_half_d;
`ifdef CE_FRAC_EN
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
`endif
    end
  end

  assign ce        = ce_q;
  assign ce_half   = ce_half_q;
  assign switching = (div_m1 != active_q) && !load_q;

endmodule

// File: rtl/ce_generator.sv
// NUM_CH independent clock-enable channels sharing one phase-sync pulse.
// Define CE_FRAC_EN to add the per-channel fractional divide (frac port).
module ce_generator
  import uk101_clk_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = DIV_W_DEF
`ifdef CE_FRAC_EN
  , parameter int unsigned FRAC_W = FRAC_W_DEF
`endif
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_m1,
`ifdef CE_FRAC_EN
  input  logic [NUM_CH*FRAC_W-1:0] frac,
`endif
  input  logic [NUM_CH-1:0]       pause,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       ce_half,
  output logic [NUM_CH-1:0]       switching
);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      ce_divider_ch #(
        .DIV_W (DIV_W)
`ifdef CE_FRAC_EN
        , .FRAC_W(FRAC_W)
`endif
      ) u_ch (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .div_m1    (div_m1[g*DIV_W +: DIV_W]),
`ifdef CE_FRAC_EN
        .frac      (frac[g*FRAC_W +: FRAC_W]),
`endif
        .pause     (pause[g]),
        .sync      (sync),
        .ce        (ce[g]),
        .ce_half   (ce_half[g]),
        .switching (switching[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ce_generator.sv
// Self-checking bench for ce_generator: expected enable edges are queued per channel
// when stimulus is applied and matched against each observed ce/ce_half pulse.
module tb_ce_generator;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DIV_W  = 6;
  localparam int unsigned FRAC_W = 8;

  logic                    clk_sys = 1'b0;
  logic                    reset;
  logic [NUM_CH*DIV_W-1:0] div_m1;
`ifdef CE_FRAC_EN
  logic [NUM_CH*FRAC_W-1:0] frac;
`endif
  logic [NUM_CH-1:0]       pause;
  logic                    sync;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       ce_half;
  logic [NUM_CH-1:0]       switching;

  ce_generator #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .div_m1    (div_m1),
`ifdef CE_FRAC_EN
    .frac      (frac),
`endif
    .pause     (pause),
    .sync      (sync),
    .ce        (ce),
    .ce_half   (ce_half),
    .switching (switching)
  );

  always #10 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;
  bit sw_chk = 1'b0;
  logic [NUM_CH-1:0] exp_sw = '0;

  int q_ce0[$];
  int q_ce1[$];
  int q_h0[$];
  int q_h1[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic match_pulse(input string tag, inout int q[$]);
    if (q.size() == 0) check_val({tag, "_unexpected"}, edge_n, -1);
    else               check_val(tag, edge_n, q.pop_front());
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
    edge_n++;
    if (mon_en) begin
      if (ce[0])      match_pulse("ce0_edge", q_ce0);
      if (ce[1])      match_pulse("ce1_edge", q_ce1);
      if (ce_half[0]) match_pulse("half0_edge", q_h0);
      if (ce_half[1]) match_pulse("half1_edge", q_h1);
    end
    if (sw_chk) check_val("switching", int'(switching), int'(exp_sw));
  endtask

  task automatic check_drained(input string phase);
    check_val({phase, "_ce0_left"},   q_ce0.size(), 0);
    check_val({phase, "_ce1_left"},   q_ce1.size(), 0);
    check_val({phase, "_half0_left"}, q_h0.size(),  0);
    check_val({phase, "_half1_left"}, q_h1.size(),  0);
  endtask

  initial begin
    reset  = 1'b1;
    sync   = 1'b0;
    pause  = '0;
    div_m1 = '0;
    div_m1[0*DIV_W +: DIV_W] = 6'd5;
    div_m1[1*DIV_W +: DIV_W] = 6'd11;
`ifdef CE_FRAC_EN
    frac = '0;
`endif

    repeat (3) @(posedge clk_sys);
    #1;
    check_val("rst_ce",   int'(ce),        0);
    check_val("rst_half", int'(ce_half),   0);
    check_val("rst_sw",   int'(switching), 0);

    // Release mid-cycle; the next rising edge is edge 1.
    reset  = 1'b0;
    edge_n = 0;
    q_ce0 = '{7, 13, 25, 37};
    q_h0  = '{4, 10, 19, 31};
    q_ce1 = '{13, 25, 37};
    q_h1  = '{7, 19, 31};
    mon_en = 1'b1;
    sw_chk = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 9) begin
        div_m1[0*DIV_W +: DIV_W] = 6'd11;
        exp_sw = 2'b01;
      end
      if (e == 12) exp_sw = '0;
    end
    check_drained("startup");
    sw_chk = 1'b0;

    // Sync on edge 41 with channel 1 paused: sync must still realign it.
    div_m1[0*DIV_W +: DIV_W] = 6'd5;
    q_ce0 = '{47, 53, 63, 69};
    q_h0  = '{44, 50, 60, 66, 72};
    q_ce1 = '{53, 65};
    q_h1  = '{47, 59, 71};
    sync  = 1'b1;
    pause = 2'b10;
    step();
    sync  = 1'b0;
    pause = '0;
    for (int e = 42; e <= 72; e++) begin
      step();
      if (e == 54) pause = 2'b01;
      if (e == 58) pause = '0;
    end
    check_drained("sync_pause");

    // Divisor 0 takes effect at the wrap on edge 75, then ce every cycle.
    div_m1[0*DIV_W +: DIV_W] = 6'd0;
    q_ce0 = '{75, 76, 77, 78, 79, 80};
    q_h0  = '{76, 77, 78, 79, 80};
    q_ce1 = '{77};
    for (int e = 73; e <= 80; e++) step();
    check_drained("div0");

    check_val("ce0_live", int'(ce[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("ce0_async_rst",   int'(ce[0]),      0);
    check_val("half0_async_rst", int'(ce_half[0]), 0);
    mon_en = 1'b0;

`ifdef CE_FRAC_EN
    begin
      int gap, total, pmin, pmax;
      div_m1[0*DIV_W +: DIV_W]   = 6'd3;
      frac[0*FRAC_W +: FRAC_W]   = 8'd205;
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      gap = 0;
      while (!ce[0] && gap < 20) begin
        step();
        gap++;
      end
      check_val("frac_first_ce", int'(ce[0]), 1);
      total = 0;
      pmin  = 99;
      pmax  = 0;
      for (int p = 0; p < 256; p++) begin
        gap = 0;
        do begin
          step();
          gap++;
        end while (!ce[0] && gap < 10);
        total += gap;
        if (gap < pmin) pmin = gap;
        if (gap > pmax) pmax = gap;
      end
      check_val("frac_total_1229pm1", int'(total >= 1228 && total <= 1230), 1);
      check_val("frac_min_ge4", int'(pmin >= 4), 1);
      check_val("frac_max_le5", int'(pmax <= 5), 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ce_generator.md
Name: ce_generator

Overview:
Multi-channel clock-enable generator running on clk_sys (48 MHz). Replaces the single hard-coded pixel-enable counter in the emu top level with NUM_CH independent divided enables, such as pixel CE and CPU CE.
- Each channel has a runtime-programmable divisor that switches glitch-free at the period boundary.
- Each channel produces a mid-period enable for phi1/phi2-style use.
- Per-channel pause, global phase sync, and an optional fractional divide are provided.

Parameters:
NUM_CH, 2, number of independent enable channels
DIV_W, 6, width of per-channel divisor (period minus one)
FRAC_W, 8, fractional accumulator width (used only with CE_FRAC_EN)

Ports:
clk_sys  in  1  system clock, 48 MHz
reset  in  1  asynchronous, active-high reset
div_m1  in  NUM_CH*DIV_W  per-channel period minus one; channel i occupies bits [i*DIV_W +: DIV_W]
frac  in  NUM_CH*FRAC_W  per-channel fractional period increment (present only with CE_FRAC_EN)
pause  in  NUM_CH  per-channel freeze, e.g. during ioctl download
sync  in  1  global phase realign pulse
ce  out  NUM_CH  one-cycle enable at period end
ce_half  out  NUM_CH  one-cycle enable at mid-period
switching  out  NUM_CH  divisor change pending, waiting for the boundary

Behaviour:
Per-channel state:
- count[DIV_W], active_m1[DIV_W], load flag, stretch flag, acc[FRAC_W] (the last two only with CE_FRAC_EN).
- Reset values: count=0, active_m1=0, load=1, stretch=0, acc=0, ce=0, ce_half=0. switching=0 because load=1 masks it.

Registered outputs and timing:
- ce and ce_half are registered; each is high for exactly one cycle.
- Precedence per cycle, highest first: sync, then pause, then load, then normal count.
- sync=1 (overrides pause): count<=0, active_m1<=div_m1, load<=0, acc<=0, stretch<=0, ce<=0, ce_half<=0. All channels are phase-aligned afterwards.
- pause=1: all state held, ce=0, ce_half=0. Any pending divisor change stays pending.
- load=1, the first enabled cycle after reset: active_m1<=div_m1, count<=0, load<=0, no ce.
- Normal count, not at the end: count!=active_m1 gives count<=count+1, ce<=0.
  - ce_half<=1 when count==active_m1>>1.
  - When active_m1==0, ce_half mirrors ce.
- Normal count, at the end: count==active_m1 (and no stretch owed) gives count<=0, ce<=1.
  - active_m1<=div_m1, sampled in this same cycle, so a change coincident with the wrap takes effect immediately.
- Resulting timing after reset release:
  - The first ce is asserted after edge div_m1+2.
  - After that, ce repeats every div_m1+1 cycles.
  - Example: div_m1=5 gives ce after edges 7, 13, 19, …
- A mid-period change to div_m1 never shortens or lengthens the current period.
- switching = (div_m1 != active_m1) && !load.
- A channel with div_m1=0 asserts ce every cycle.
- count never exceeds active_m1, so no wrap-past-limit case exists.
- Reset asserted mid-period clears all state asynchronously. Outputs drop in the same cycle.

Optional Feature:
Macro CE_FRAC_EN.
- Enabled: at each end-of-period, {carry, acc} <= acc + frac.
  - If carry=1, the period is stretched by one cycle: count holds at active_m1 for one extra cycle, stretch=1, ce is deferred to the following cycle.
  - ce_half is unaffected.
  - Average period = div_m1 + 1 + frac/2^FRAC_W. Example: div_m1=3, frac=205 approximates 4.8 cycles, i.e. 10 MHz from 48 MHz.
- Disabled: the frac port, acc and stretch do not exist; periods are strictly integer.

Decomposition:
Package uk101_clk_pkg holds:
- Default DIV_W and FRAC_W.
- 48 MHz divisor constants: CE_PIX_LO_M1=11, CE_PIX_HI_M1=5, CE_CPU_1M_M1=47, CE_CPU_2M_M1=23, CE_CPU_4M_M1=11, CE_CPU_8M_M1=5, CE_CPU_10M_M1=3, CE_CPU_10M_FRAC=205.
- A function mapping the 3-bit cpuOverclock code to a divisor.

Sub-module ce_divider_ch implements one channel. ce_generator instantiates NUM_CH copies with a shared sync.

Test Plan:
- Reset release with div_m1=5, no pause/sync -> ce high after edges 7, 13, 19; ce_half after edges 4, 10, 16; switching=0 throughout.
- div_m1 changed 5->11 at edge 9 (mid-period) -> switching=1 from edge 9 until the wrap at edge 13; next ce at edge 25; ce period 12 thereafter.
- pause held 4 cycles mid-period with div_m1=5 -> ce/ce_half held low; the next ce is delayed exactly 4 cycles; count resumes from its held value.
- Channels at div_m1=5 and 11, sync pulsed at an arbitrary edge -> both channels emit ce exactly 6 and 12 cycles later; sync while pause=1 still zeroes count.
- div_m1=0 -> ce=1 every cycle after load; asserting reset mid-stream drops ce asynchronously.
- CE_FRAC_EN with div_m1=3, frac=205 -> over 256 periods, total cycles = 256*4+205 = 1229 ±1; no period shorter than 4 or longer than 5.
